// File: rtl/ctrl_pkg.sv
// Opcode map, control-word bit layout and sequencer state encoding shared by the decode stage.
package ctrl_pkg;

   localparam int CTRL_BITS = 22;
   typedef logic [CTRL_BITS-1:0] ctrl_word_t;

   localparam int B_WB    = 0;
   localparam int B_MEMWR = 1;
   localparam int B_MEMRD = 2;
   localparam int B_CALL  = 3;
   localparam int B_OUT   = 4;
   localparam int B_IN    = 5;
   localparam int B_LDD   = 6;
   localparam int B_RTI   = 7;
   localparam int B_RET   = 8;
   localparam int B_POP   = 9;
   localparam int B_PUSH  = 10;
   localparam int B_FP    = 11;
   localparam int B_JMP   = 12;
   localparam int B_STD   = 13;
   localparam int B_IMM   = 14;
   localparam int B_LDM   = 15;
   localparam int B_JZ    = 16;
   localparam int B_JN    = 17;
   localparam int B_JC    = 18;
   localparam int B_MOV   = 19;
   localparam int B_SETC  = 20;
   localparam int B_CLRC  = 21;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_MOV  = 5'b00100;
   localparam logic [4:0] OP_SETC = 5'b00101;
   localparam logic [4:0] OP_CLRC = 5'b00110;
   localparam logic [4:0] OP_LDM  = 5'b00111;
   localparam logic [4:0] OP_NOT  = 5'b01000;
   localparam logic [4:0] OP_INC  = 5'b01001;
   localparam logic [4:0] OP_OUT  = 5'b01010;
   localparam logic [4:0] OP_IN   = 5'b01011;
   localparam logic [4:0] OP_PUSH = 5'b01100;
   localparam logic [4:0] OP_POP  = 5'b01101;
   localparam logic [4:0] OP_LDD  = 5'b01110;
   localparam logic [4:0] OP_STD  = 5'b01111;
   localparam logic [4:0] OP_JZ   = 5'b11000;
   localparam logic [4:0] OP_JN   = 5'b11001;
   localparam logic [4:0] OP_JC   = 5'b11010;
   localparam logic [4:0] OP_JMP  = 5'b11011;
   localparam logic [4:0] OP_CALL = 5'b11100;
   localparam logic [4:0] OP_RTI  = 5'b11101;
   localparam logic [4:0] OP_RET  = 5'b11110;
   localparam logic [4:0] OP_NOP  = 5'b11111;

   localparam ctrl_word_t W_WB    = ctrl_word_t'(1) << B_WB;
   localparam ctrl_word_t W_MEMWR = ctrl_word_t'(1) << B_MEMWR;
   localparam ctrl_word_t W_MEMRD = ctrl_word_t'(1) << B_MEMRD;
   localparam ctrl_word_t W_CALL  = ctrl_word_t'(1) << B_CALL;
   localparam ctrl_word_t W_OUT   = ctrl_word_t'(1) << B_OUT;
   localparam ctrl_word_t W_IN    = ctrl_word_t'(1) << B_IN;
   localparam ctrl_word_t W_LDD   = ctrl_word_t'(1) << B_LDD;
   localparam ctrl_word_t W_RTI   = ctrl_word_t'(1) << B_RTI;
   localparam ctrl_word_t W_RET   = ctrl_word_t'(1) << B_RET;
   localparam ctrl_word_t W_POP   = ctrl_word_t'(1) << B_POP;
   localparam ctrl_word_t W_PUSH  = ctrl_word_t'(1) << B_PUSH;
   localparam ctrl_word_t W_FP    = ctrl_word_t'(1) << B_FP;
   localparam ctrl_word_t W_JMP   = ctrl_word_t'(1) << B_JMP;
   localparam ctrl_word_t W_STD   = ctrl_word_t'(1) << B_STD;
   localparam ctrl_word_t W_IMM   = ctrl_word_t'(1) << B_IMM;
   localparam ctrl_word_t W_LDM   = ctrl_word_t'(1) << B_LDM;
   localparam ctrl_word_t W_JZ    = ctrl_word_t'(1) << B_JZ;
   localparam ctrl_word_t W_JN    = ctrl_word_t'(1) << B_JN;
   localparam ctrl_word_t W_JC    = ctrl_word_t'(1) << B_JC;
   localparam ctrl_word_t W_MOV   = ctrl_word_t'(1) << B_MOV;
   localparam ctrl_word_t W_SETC  = ctrl_word_t'(1) << B_SETC;
   localparam ctrl_word_t W_CLRC  = ctrl_word_t'(1) << B_CLRC;

   localparam ctrl_word_t NOP_WORD       = W_IMM | W_FP;
   localparam ctrl_word_t LDM_WORD       = W_WB | W_MEMRD | W_FP | W_IMM | W_LDM;
   localparam ctrl_word_t RTI_FLAGS_WORD = W_RTI | W_MEMRD | W_FP | W_IMM;
   localparam ctrl_word_t RTI_PC_WORD    = W_RET | W_MEMRD | W_FP | W_IMM;
   localparam ctrl_word_t INT_PUSH_WORD  = W_PUSH | W_MEMWR | W_FP;
   localparam ctrl_word_t INT_VEC_WORD   = W_JMP | W_FP;

   typedef enum logic [2:0] {
      DECODE,
      IMM,
      RTI2,
      INT1,
      INT2,
      INT3
   } seq_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode-to-control-word lookup; unknown opcodes fall back to the NOP word.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPC_W  = 5,
   parameter int CTRL_W = 22
) (
   input  logic [OPC_W-1:0]  opcode_i,
   output logic [CTRL_W-1:0] ctrl_o
);

   ctrl_word_t word;

   // LDM and RTI return the word for their first emitted step; the sequencer owns the rest.
   always_comb begin
      word = NOP_WORD;
      case (opcode_i)
         OPC_W'(OP_ADD), OPC_W'(OP_SUB),
         OPC_W'(OP_AND), OPC_W'(OP_OR):   word = W_WB;
         OPC_W'(OP_MOV):                  word = W_WB | W_MOV;
         OPC_W'(OP_SETC):                 word = W_SETC;
         OPC_W'(OP_CLRC):                 word = W_CLRC;
         OPC_W'(OP_LDM):                  word = LDM_WORD;
         OPC_W'(OP_NOT), OPC_W'(OP_INC):  word = W_WB | W_IMM;
         OPC_W'(OP_OUT):                  word = W_OUT | W_FP;
         OPC_W'(OP_IN):                   word = W_IN | W_WB | W_FP;
         OPC_W'(OP_PUSH):                 word = W_PUSH | W_MEMWR | W_FP;
         OPC_W'(OP_POP):                  word = W_POP | W_MEMRD | W_WB | W_FP;
         OPC_W'(OP_LDD):                  word = W_LDD | W_MEMRD | W_WB | W_FP;
         OPC_W'(OP_STD):                  word = W_STD | W_MEMWR | W_FP;
         OPC_W'(OP_JZ):                   word = W_JZ | W_FP;
         OPC_W'(OP_JN):                   word = W_JN | W_FP;
         OPC_W'(OP_JC):                   word = W_JC | W_FP;
         OPC_W'(OP_JMP):                  word = W_JMP | W_FP;
         OPC_W'(OP_CALL):                 word = W_CALL | W_PUSH | W_MEMWR | W_FP;
         OPC_W'(OP_RTI):                  word = RTI_FLAGS_WORD;
         OPC_W'(OP_RET):                  word = W_RET | W_POP | W_MEMRD | W_FP;
         OPC_W'(OP_NOP):                  word = NOP_WORD;
         default:                         word = NOP_WORD;
      endcase
      ctrl_o = CTRL_W'(word);
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// ID/EX decode register with multi-cycle sequencing for LDM, RTI and interrupt entry,
// a valid/ready handshake toward fetch, and stall/flush from the hazard unit.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int OPC_W   = 5,
   parameter int OPC_LSB = 11,
   parameter int CTRL_W  = 22,
   parameter bit INT_EN  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic               stall,
   input  logic               flush,
   input  logic               irq,
   output logic [CTRL_W-1:0]  ctrl,
   output logic               ctrl_valid,
   output logic [INSTR_W-1:0] imm,
   output logic [1:0]         int_op,
   output logic               busy
);

   seq_state_t         state_q;
   logic [CTRL_W-1:0]  ctrl_q;
   logic               ctrlValid_q;
   logic [INSTR_W-1:0] imm_q;
   logic [1:0]         intOp_q;
   logic               irqPend_q;

   logic [OPC_W-1:0]   opcode;
   logic [CTRL_W-1:0]  decodedCtrl;
   logic               isLdm;
   logic               irqTake;
   logic               accept;
   logic               inIntState;

   ctrl_decode #(
      .OPC_W  (OPC_W),
      .CTRL_W (CTRL_W)
   ) uDecode (
      .opcode_i (opcode),
      .ctrl_o   (decodedCtrl)
   );

   // An interrupt only starts from DECODE, so an open LDM/RTI sequence always completes first.
   assign opcode      = instr[OPC_LSB +: OPC_W];
   assign isLdm       = (opcode == OPC_W'(OP_LDM));
   assign irqTake     = INT_EN && irqPend_q && !stall && !flush && (state_q == DECODE);
   assign inIntState  = (state_q == INT1) || (state_q == INT2) || (state_q == INT3);
   assign instr_ready = ((state_q == DECODE) || (state_q == IMM)) && !stall && !irqTake;
   assign accept      = instr_valid && instr_ready;

   assign ctrl       = ctrl_q;
   assign ctrl_valid = ctrlValid_q;
   assign imm        = imm_q;
   assign int_op     = intOp_q;
   assign busy       = (state_q != DECODE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DECODE;
         ctrl_q      <= '0;
         ctrlValid_q <= 1'b0;
         imm_q       <= '0;
         intOp_q     <= 2'd0;
         irqPend_q   <= 1'b0;
      end else begin
         // Flush beats stall but cannot interrupt the atomic interrupt-entry sequence.
         if (flush && !inIntState) begin
            state_q     <= DECODE;
            ctrlValid_q <= 1'b0;
            imm_q       <= '0;
         end else if (!stall) begin
            case (state_q)
               DECODE: begin
                  imm_q <= '0;
                  if (irqTake) begin
                     state_q     <= INT1;
                     ctrl_q      <= CTRL_W'(INT_PUSH_WORD);
                     ctrlValid_q <= 1'b1;
                     intOp_q     <= 2'd1;
                  end else if (accept && isLdm) begin
                     state_q     <= IMM;
                     ctrlValid_q <= 1'b0;
                  end else if (accept) begin
                     state_q     <= (opcode == OPC_W'(OP_RTI)) ? RTI2 : DECODE;
                     ctrl_q      <= decodedCtrl;
                     ctrlValid_q <= 1'b1;
                  end else begin
                     ctrlValid_q <= 1'b0;
                  end
               end
               IMM: begin
                  if (accept) begin
                     state_q     <= DECODE;
                     ctrl_q      <= CTRL_W'(LDM_WORD);
                     ctrlValid_q <= 1'b1;
                     imm_q       <= instr;
                  end else begin
                     ctrlValid_q <= 1'b0;
                     imm_q       <= '0;
                  end
               end
               RTI2: begin
                  state_q     <= DECODE;
                  ctrl_q      <= CTRL_W'(RTI_PC_WORD);
                  ctrlValid_q <= 1'b1;
                  imm_q       <= '0;
               end
               INT1: begin
                  state_q     <= INT2;
                  ctrl_q      <= CTRL_W'(INT_PUSH_WORD);
                  ctrlValid_q <= 1'b1;
                  intOp_q     <= 2'd2;
               end
               INT2: begin
                  state_q     <= INT3;
                  ctrl_q      <= CTRL_W'(INT_VEC_WORD);
                  ctrlValid_q <= 1'b1;
                  intOp_q     <= 2'd3;
               end
               INT3: begin
                  state_q     <= DECODE;
                  ctrlValid_q <= 1'b0;
                  intOp_q     <= 2'd0;
                  irqPend_q   <= 1'b0;
               end
               default: begin
                  state_q     <= DECODE;
                  ctrlValid_q <= 1'b0;
                  intOp_q     <= 2'd0;
               end
            endcase
         end

         // A request still asserted while INT3 retires stays pending rather than being lost.
         if (INT_EN && irq && !stall) begin
            irqPend_q <= 1'b1;
         end
      end
   end

endmodule
